// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants for the immediate-generation pipe stage:
// RV opcodes, immediate format codes and the PC-relative pre-adjust.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_type_e;

  localparam int PC_ADJ_VAL = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV immediate decoder: assembles the 32-bit field, extends
// it to XLEN and applies the optional -4 adjust on PC-relative formats.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PC_ADJ = 1
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  logic [31:0]     field;
  logic            pc_rel;
  logic [XLEN-1:0] ext;

  always_comb begin
    field    = '0;
    pc_rel   = 1'b0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (instruction[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_type = IMM_I;
        field    = {{20{instruction[31]}}, instruction[31:20]};
      end
      OP_STORE: begin
        imm_type = IMM_S;
        field    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        pc_rel   = 1'b1;
        field    = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_JAL: begin
        imm_type = IMM_J;
        pc_rel   = 1'b1;
        field    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      end
      OP_AUIPC, OP_LUI: begin
        imm_type = IMM_U;
        pc_rel   = (instruction[6:0] == OP_AUIPC);
        field    = {instruction[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Bit 31 of the assembled field is the sign for every format.
  generate
    if (XLEN > 32) begin : g_wide
      assign ext = {{(XLEN-32){field[31]}}, field};
    end else begin : g_narrow
      assign ext = field[XLEN-1:0];
    end
  endgenerate

  assign immediate = (PC_ADJ != 0 && pc_rel) ? ext - XLEN'(PC_ADJ_VAL) : ext;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate-generation pipe stage: decoder followed by a main register and
// one skid register so in_ready depends only on state.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PC_ADJ = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;

  logic [XLEN-1:0] skid_imm_reg;
  logic [2:0]      skid_type_reg;
  logic            skid_illegal_reg;
  pipe_state_e     state_reg;

  imm_decode #(.XLEN(XLEN), .PC_ADJ(PC_ADJ)) u_decode (
    .instruction (instruction),
    .immediate   (dec_imm),
    .imm_type    (dec_type),
    .illegal     (dec_illegal)
  );

  // Output ports are the main register itself; the skid only ever feeds main.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_EMPTY;
      out_valid        <= 1'b0;
      in_ready         <= 1'b1;
      immediate        <= '0;
      imm_type         <= IMM_NONE;
      illegal          <= 1'b0;
      skid_imm_reg     <= '0;
      skid_type_reg    <= IMM_NONE;
      skid_illegal_reg <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_valid) begin
            immediate <= dec_imm;
            imm_type  <= dec_type;
            illegal   <= dec_illegal;
            out_valid <= 1'b1;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && !out_ready) begin
            skid_imm_reg     <= dec_imm;
            skid_type_reg    <= dec_type;
            skid_illegal_reg <= dec_illegal;
            in_ready         <= 1'b0;
            state_reg        <= ST_FULL;
          end else if (!in_valid && out_ready) begin
            out_valid <= 1'b0;
            state_reg <= ST_EMPTY;
          end else if (in_valid && out_ready) begin
            immediate <= dec_imm;
            imm_type  <= dec_type;
            illegal   <= dec_illegal;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            immediate <= skid_imm_reg;
            imm_type  <= skid_type_reg;
            illegal   <= skid_illegal_reg;
            in_ready  <= 1'b1;
            state_reg <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (64/adj, 64/no-adj, 32/adj)
// share stimulus and are checked against a queue-based arithmetic model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic        rdy [3];
  logic        vld [3];
  logic        ill [3];
  logic [2:0]  typ [3];
  logic [63:0] imm_a, imm_b;
  logic [31:0] imm_c;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(64), .PC_ADJ(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .instruction(instruction), .out_valid(vld[0]), .out_ready(out_ready),
    .immediate(imm_a), .imm_type(typ[0]), .illegal(ill[0]));
  imm_gen_pipe #(.XLEN(64), .PC_ADJ(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .instruction(instruction), .out_valid(vld[1]), .out_ready(out_ready),
    .immediate(imm_b), .imm_type(typ[1]), .illegal(ill[1]));
  imm_gen_pipe #(.XLEN(32), .PC_ADJ(1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .instruction(instruction), .out_valid(vld[2]), .out_ready(out_ready),
    .immediate(imm_c), .imm_type(typ[2]), .illegal(ill[2]));

  // Value of the immediate as a mathematical integer, from the format rules.
  function automatic longint ref_val(input logic [31:0] i, input bit adj,
                                     output logic [2:0] t, output bit il);
    longint v = 0;
    bit pcrel = 1'b0;
    t  = 3'd0;
    il = 1'b0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        t = 3'd1; v = longint'(i[31:20]); if (i[31]) v -= 4096;
      end
      7'b0100011: begin
        t = 3'd2; v = longint'({i[31:25], i[11:7]}); if (i[31]) v -= 4096;
      end
      7'b1100011: begin
        t = 3'd3; pcrel = 1'b1;
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
      end
      7'b1101111: begin
        t = 3'd4; pcrel = 1'b1;
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v -= 1048576;
      end
      7'b0010111, 7'b0110111: begin
        t = 3'd5; pcrel = (i[6:0] == 7'b0010111);
        v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'sd4294967296;
      end
      default: il = 1'b1;
    endcase
    if (adj && pcrel) v -= 4;
    return v;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b0010111, 7'b0110111, 7'b0000000, 7'b1111111};
    logic [31:0] r = $urandom();
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (vld[k] !== 1'b0 || rdy[k] !== 1'b1 || typ[k] !== 3'd0 || ill[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctl[%0d]: got vld=%b rdy=%b typ=%0d ill=%b, want 0 1 0 0",
                 k, vld[k], rdy[k], typ[k], ill[k]);
      end
    end
    total++;
    if (imm_a !== 64'd0 || imm_b !== 64'd0 || imm_c !== 32'd0) begin
      bad++;
      $display("FAIL reset_imm: got %h %h %h, want 0", imm_a, imm_b, imm_c);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] insts [6] = '{32'h00200013, 32'hFFE00013, 32'h00000863,
                               32'h0200006F, 32'h00001037, 32'hFFFFF017};
    logic [63:0] ea [6] = '{64'd2, -64'sd2, 64'd12, 64'd28, 64'd4096, -64'sd4100};
    logic [63:0] eb [6] = '{64'd2, -64'sd2, 64'd16, 64'd32, 64'd4096, -64'sd4096};
    logic [31:0] ec [6] = '{32'd2, 32'hFFFFFFFE, 32'd12, 32'd28, 32'd4096, 32'hFFFFEFFC};
    logic [2:0]  et [6] = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd5};
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      in_valid = 1'b1; instruction = insts[n];
      tick();
      in_valid = 1'b0;
      total++;
      if (vld[0] !== 1'b1 || imm_a !== ea[n] || imm_b !== eb[n] || imm_c !== ec[n] ||
          typ[0] !== et[n]) begin
        bad++;
        $display("FAIL directed[%h]: got vld=%b imm=%h/%h/%h typ=%0d, want 1 %h/%h/%h %0d",
                 insts[n], vld[0], imm_a, imm_b, imm_c, typ[0], ea[n], eb[n], ec[n], et[n]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h00000000;
    tick();
    in_valid = 1'b0;
    total++;
    if (vld[0] !== 1'b1 || ill[0] !== 1'b1 || imm_a !== 64'd0 || typ[0] !== 3'd0) begin
      bad++;
      $display("FAIL illegal: got vld=%b ill=%b imm=%h typ=%0d, want 1 1 0 0",
               vld[0], ill[0], imm_a, typ[0]);
    end
    tick();
    total++;
    if (vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL illegal_drain: got vld=%b, want 0", vld[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3] = '{32'h00200013, 32'hFFE00013, 32'h00001037};
    logic [63:0] exp [3] = '{64'd2, -64'sd2, 64'd4096};
    logic [63:0] got [$];
    bit          pend;
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; instruction = seq[n];
      tick();
      total++;
      if (rdy[0] !== (n == 0) || imm_a !== 64'd2 || vld[0] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: got rdy=%b vld=%b imm=%h, want %b 1 2",
                 n, rdy[0], vld[0], imm_a, n == 0);
      end
    end
    out_ready = 1'b1;
    pend = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (vld[0]) got.push_back(imm_a);
      if (pend && rdy[0]) pend = 1'b0;
      tick();
      if (!pend) in_valid = 1'b0;
    end
    total++;
    if (got.size() != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs, want 3", got.size());
    end else begin
      for (int n = 0; n < 3; n++) begin
        total++;
        if (got[n] !== exp[n]) begin
          bad++;
          $display("FAIL b2b_order[%0d]: got %h, want %h", n, got[n], exp[n]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00200013; tick();
    instruction = 32'hFFE00013; tick();
    total++;
    if (rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL flush_full: got rdy=%b, want 0", rdy[0]);
    end
    flush = 1'b1; instruction = 32'h0200006F;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL flush_empty: got vld=%b rdy=%b, want 0 1", vld[0], rdy[0]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (vld[0] !== 1'b0) begin
        bad++;
        $display("FAIL flush_leak: got vld=%b imm=%h, want 0", vld[0], imm_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00000863; tick();
    instruction = 32'h0200006F; tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1 || imm_a !== 64'd0 || typ[0] !== 3'd0 ||
        ill[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got vld=%b rdy=%b imm=%h typ=%0d ill=%b, want 0 1 0 0 0",
               vld[0], rdy[0], imm_a, typ[0], ill[0]);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h00001037;
    tick();
    in_valid = 1'b0;
    total++;
    if (vld[0] !== 1'b1 || imm_a !== 64'd4096) begin
      bad++;
      $display("FAIL reset_first: got vld=%b imm=%h, want 1 1000", vld[0], imm_a);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [63:0] got [3];
    logic [63:0] exp [3];
    logic [2:0]  et;
    bit          eil;
    bit          ev, er, acc, drn;
    for (int c = 0; c < 400; c++) begin
      ev = (q.size() > 0);
      er = (q.size() < 2);
      got[0] = imm_a; got[1] = imm_b; got[2] = {32'd0, imm_c};
      if (ev) begin
        exp[0] = 64'(ref_val(q[0], 1'b1, et, eil));
        exp[1] = 64'(ref_val(q[0], 1'b0, et, eil));
        exp[2] = {32'd0, exp[0][31:0]};
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (vld[k] !== ev || rdy[k] !== er) begin
          bad++;
          $display("FAIL rand_hs[%0d] cyc %0d: got vld=%b rdy=%b, want %b %b",
                   k, c, vld[k], rdy[k], ev, er);
        end
        if (ev) begin
          total++;
          if (got[k] !== exp[k] || typ[k] !== et || ill[k] !== eil) begin
            bad++;
            $display("FAIL rand_data[%0d] inst %h: got %h t=%0d i=%b, want %h t=%0d i=%b",
                     k, q[0], got[k], typ[k], ill[k], exp[k], et, eil);
          end
        end
      end
      in_valid    = ($urandom_range(0, 2) != 0);
      instruction = rand_inst();
      out_ready   = ($urandom_range(0, 2) != 0);
      acc = in_valid && er;
      drn = ev && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(instruction);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
